// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one cipher round per clock, on-the-fly key expansion
// Ports: clk, rst (sync, active-high); in_valid/in_ready + plaintext/key accept a block;
// out_valid/out_ready + ciphertext return it; busy high in ROUND/DONE; round = index in ROUND else 0.
// Byte k of any 128-bit bus is bits [127-8k -: 8] (byte 0 is the leftmost hex pair); state s[r][c] = byte 4c+r.
module aes128_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  // Entry 255 holds sbox(0x00), so sbox(b) = SBOX[~b].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[~b];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sb(s[8*i +: 8]);
    return o;
  endfunction
  // Row r rotates left by r columns: s'[r][c] = s[r][(c+r)%4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7, t;
    t  = {rk[23:0], rk[31:24]};
    w4 = rk[127:96] ^ {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    w5 = rk[95:64] ^ w4;
    w6 = rk[63:32] ^ w5;
    w7 = rk[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction
  state_t       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, ct_q, ct_d, sr, nk;
  logic [3:0]   rnd_q, rnd_d;
  assign sr = shift_rows(sub_bytes(st_q));
  assign nk = key_expand(rk_q, rcon(rnd_q));
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d    = plaintext ^ key;
        rk_d    = key;
        rnd_d   = 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        rk_d = nk;
        if (rnd_q == 4'(NR)) begin
          ct_d    = sr ^ nk;
          state_d = DONE;
        end else begin
          st_d  = mix_columns(sr) ^ nk;
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign round      = state_q == ROUND ? rnd_q : 4'd0;
  assign ciphertext = ct_q;
endmodule
